// File: rtl/seg7_if.sv
// -----------------------------------------------------------------------------
// seg7_if -- bundle between a value source and the 3-digit 7-segment scanner.
//
// Signals:
//   en   display enable (0 = all digits dark, scanning keeps running)
//   bcd  packed BCD value: [3:0] units, [7:4] tens, [11:8] hundreds
//   an   active-low digit enables: [0] units, [1] tens, [2] hundreds
//   seg  active-low segments {g,f,e,d,c,b,a}
//
// Modports:
//   master  value source / board side: drives en, bcd; observes an, seg
//   slave   the scanner: reads en, bcd; drives an, seg
// -----------------------------------------------------------------------------
interface seg7_if;
    logic        en;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    modport master (output en, output bcd, input an, input seg);
    modport slave  (input en, input bcd, output an, output seg);
endinterface

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan -- time-multiplexed driver for a 3-digit common-anode 7-segment
// display fed by a packed BCD value.
//
// A prescaler produces a one-cycle tick every TICK_DIV clocks. Each tick moves
// the scan FSM to the next digit (units -> tens -> hundreds -> units). The BCD
// input is captured into a shadow register only at the end of a frame, so one
// frame always shows one coherent value. an/seg are registered and lag the scan
// state by one clock.
//
// Parameters:
//   TICK_DIV  clk cycles per digit slot, 1..65535 (default 1000)
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous, active-high reset
//   dsp  seg7_if.slave: en, bcd in; an, seg out
//
// Build option:
//   SEG7_LEAD_ZERO_BLANK_EN  when defined, leading zeros are blanked
//                            (hundreds if 0; tens if hundreds and tens are 0;
//                            units never blanked).
// -----------------------------------------------------------------------------
module seg7_scan #(
    parameter int TICK_DIV = 1000
) (
    input  logic   clk,
    input  logic   rst,
    seg7_if.slave  dsp
);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,   // units
        DIG1 = 2'd1,   // tens
        DIG2 = 2'd2    // hundreds
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_p0;
    logic        tick_p0;
    state_t      state_p0;
    state_t      state_nxt;
    logic [11:0] shadow_p0;

    logic [3:0]  nib;
    logic        blank;
    logic [2:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic [2:0]  an_p1;
    logic [6:0]  seg_p1;

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // ---- stage p0: prescaler, scan state, frame shadow ----
    assign tick_p0 = (presc_p0 == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_p0 <= 16'd0;
        end else if (tick_p0) begin
            presc_p0 <= 16'd0;
        end else begin
            presc_p0 <= presc_p0 + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= DIG0;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        if (tick_p0) begin
            case (state_p0)
                DIG0:    state_nxt = DIG1;
                DIG1:    state_nxt = DIG2;
                default: state_nxt = DIG0;
            endcase
        end
    end

    // Capture on the last tick of a frame so the next frame starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_p0 <= 12'h000;
        end else if (tick_p0 && (state_p0 == DIG2)) begin
            shadow_p0 <= dsp.bcd;
        end
    end

    // ---- stage p1: digit select, blanking, segment decode ----
    always_comb begin
        nib    = shadow_p0[3:0];
        blank  = 1'b1;
        an_nxt = 3'b111;
        case (state_p0)
            DIG0: begin
                nib    = shadow_p0[3:0];
                an_nxt = 3'b110;
                blank  = 1'b0;
            end
            DIG1: begin
                nib    = shadow_p0[7:4];
                an_nxt = 3'b101;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
                blank  = (shadow_p0[11:8] == 4'd0) && (shadow_p0[7:4] == 4'd0);
`else
                blank  = 1'b0;
`endif
            end
            DIG2: begin
                nib    = shadow_p0[11:8];
                an_nxt = 3'b011;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
                blank  = (shadow_p0[11:8] == 4'd0);
`else
                blank  = 1'b0;
`endif
            end
            default: begin
                blank  = 1'b1;
            end
        endcase

        seg_nxt = seg_decode(nib);
        if (!dsp.en || blank) begin
            an_nxt  = 3'b111;
            seg_nxt = 7'b1111111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_p1  <= 3'b111;
            seg_p1 <= 7'b1111111;
        end else begin
            an_p1  <= an_nxt;
            seg_p1 <= seg_nxt;
        end
    end

    assign dsp.an  = an_p1;
    assign dsp.seg = seg_p1;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 1000, giving the number of clk cycles per digit slot; legal range is 1 to 65535.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  display enable; when 0, all digits are dark but scanning continues.
REQ-005 bcd  input  12  packed BCD count from the bin2bcd stage: [3:0] units, [7:4] tens, [11:8] hundreds.
REQ-006 an  output  3  active-low digit enables: [0] units, [1] tens, [2] hundreds.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-008 A prescaler SHALL count 0 to TICK_DIV-1 and wrap; tick is asserted for exactly one cycle when the count equals TICK_DIV-1; with TICK_DIV=1, tick is asserted every cycle.
REQ-009 A scan FSM SHALL have states DIG0 (units), DIG1 (tens) and DIG2 (hundreds), advancing DIG0->DIG1->DIG2->DIG0 only on tick and holding otherwise.
REQ-010 A 12-bit shadow register SHALL load bcd on the cycle where tick=1 and state=DIG2, so that each frame displays one coherent value and changes to bcd mid-frame never tear.
REQ-011 an and seg SHALL be registered outputs, decoded from the current state and shadow, and SHALL lag the state by one clk.
REQ-012 Exactly one an bit SHALL be low per cycle, namely the one matching the state, unless en=0 or the digit is blanked, in which case an=3'b111 and seg=7'b1111111.
REQ-013 Segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-014 Any nibble value 10 to 15 SHALL display a dash, seg=0111111.
REQ-015 A change of en SHALL take effect on an/seg one clk later and SHALL NOT disturb the prescaler, FSM or shadow.

Reset
REQ-016 While rst=1 the block SHALL immediately force: prescaler=0, state=DIG0, shadow=12'h000, an=3'b111, seg=7'b1111111.
REQ-017 Assertion of rst mid-slot or mid-frame SHALL discard the partial slot; after release, the first tick occurs TICK_DIV cycles later.
REQ-018 Until the first shadow load after reset, the display SHALL show the value 000, subject to REQ-020.

Configuration
REQ-019 Macro SEG7_LEAD_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-020 With SEG7_LEAD_ZERO_BLANK_EN defined: the hundreds digit SHALL be blanked when it is 0; the tens digit SHALL be blanked when hundreds and tens are both 0; the units digit SHALL never be blanked.
REQ-021 Without SEG7_LEAD_ZERO_BLANK_EN: all three digits SHALL always be displayed, with zeros shown as 1000000.

Verification
REQ-022 TICK_DIV=4, bcd=12'h123, en=1: after the first shadow load, the following frame gives an=110/seg=0110000, then an=101/seg=0100100, then an=011/seg=1111001, with each slot lasting 4 cycles.
REQ-023 Tearing: bcd changes from 12'h123 to 12'h456 during DIG1 -> the current frame still shows 1,2,3, and 4,5,6 appear from the next DIG0.
REQ-024 bcd=12'h007 -> with the macro, an cycles 110 then 111 then 111 with seg=1111000 in the units slot; without the macro, the tens and hundreds slots show 1000000.
REQ-025 bcd=12'h0A0 -> the tens slot shows seg=0111111; bcd=12'h000 with the macro -> the units slot shows 1000000.
REQ-026 Assert rst during DIG2 -> an=111 and seg=1111111 within the same cycle, without waiting for a clk edge; after release, state=DIG0 and shadow=000.
REQ-027 en=0 for 10 cycles with TICK_DIV=1 -> an=111 throughout, and the FSM continues to advance, so digit position on re-enable matches an uninterrupted run.
